// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator
// Pixel divider, h/v counters and a registered, mutually aligned decode of sync/video/strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  output logic               pix_tick,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             tick_i;
  logic             h_last;
  logic             v_last;
  logic             at_origin;
  logic             in_hsync;
  logic             in_vsync;
  logic             in_active;

  assign tick_i    = enable && (div == DIV_W'(CLK_DIV - 1));
  assign h_last    = (h == CNT_W'(H_TOTAL - 1));
  assign v_last    = (v == CNT_W'(V_TOTAL - 1));
  assign at_origin = (h == '0) && (v == '0);
  assign in_hsync  = (h >= CNT_W'(HS_FIRST)) && (h <= CNT_W'(HS_LAST));
  assign in_vsync  = (v >= CNT_W'(VS_FIRST)) && (v <= CNT_W'(VS_LAST));
  assign in_active = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      pix_tick    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      h_sync      <= ~HSYNC_POL;
      v_sync      <= ~VSYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (restart) begin
      // Level outputs and frame_cnt deliberately hold across a restart.
      div         <= '0;
      h           <= '0;
      v           <= '0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick_i;
      line_start  <= tick_i && (h == '0);
      frame_start <= tick_i && at_origin;
      if (enable) begin
        div <= tick_i ? '0 : div + 1'b1;
      end
      if (tick_i) begin
        // Outputs present the counter value before it advances.
        pixel_x  <= h;
        pixel_y  <= v;
        video_on <= in_active;
        h_sync   <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
        v_sync   <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
        if (at_origin) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen
// Two configurations checked every clock against a pixel-index model, plus literal checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic restart;

  always #5 clk = ~clk;

  logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [15:0] a_fc;
  logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [3:0] b_fc;

  vga_timing_gen #(
    .CLK_DIV(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .pix_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y), .h_sync(a_hs), .v_sync(a_vs),
    .video_on(a_von), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(10), .FRAME_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .pix_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y), .h_sync(b_hs), .v_sync(b_vs),
    .video_on(b_von), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  int ha[2]   = '{640, 4};
  int hfp[2]  = '{16, 1};
  int hsw[2]  = '{96, 2};
  int hbp[2]  = '{48, 1};
  int va[2]   = '{6, 3};
  int vfp[2]  = '{1, 1};
  int vsw[2]  = '{2, 1};
  int vbp[2]  = '{2, 1};
  int dv[2]   = '{2, 1};
  int pol[2]  = '{0, 1};
  int fmod[2] = '{65536, 16};

  longint en_cnt[2];
  int e_tick[2], e_x[2], e_y[2], e_hs[2], e_vs[2], e_von[2], e_ls[2], e_fs[2], e_fc[2];

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input longint act, input longint exp);
    chk(nm, 0, act, exp);
  endtask

  task automatic wait_a(input int x, input int y, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (a_tick && a_x == x && a_y == y) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_a timeout waiting for (%0d,%0d) at %0t", x, y, $time);
    end
  endtask

  // Model: pixel index = enabled clocks since restart / CLK_DIV; position follows by division.
  always @(posedge clk) begin
    longint p;
    int ht, vt, x, y, tk;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ht = ha[i] + hfp[i] + hsw[i] + hbp[i];
      vt = va[i] + vfp[i] + vsw[i] + vbp[i];
      if (reset) begin
        en_cnt[i] = 0;
        e_tick[i] = 0; e_ls[i] = 0; e_fs[i] = 0;
        e_x[i] = 0; e_y[i] = 0; e_von[i] = 0; e_fc[i] = 0;
        e_hs[i] = 1 - pol[i]; e_vs[i] = 1 - pol[i];
      end else if (restart) begin
        en_cnt[i] = 0;
        e_tick[i] = 0; e_ls[i] = 0; e_fs[i] = 0;
      end else begin
        tk = (enable && (en_cnt[i] % dv[i] == dv[i] - 1)) ? 1 : 0;
        e_tick[i] = tk; e_ls[i] = 0; e_fs[i] = 0;
        if (tk == 1) begin
          p = en_cnt[i] / dv[i];
          x = int'(p % ht);
          y = int'((p / ht) % vt);
          e_x[i] = x;
          e_y[i] = y;
          e_von[i] = (x < ha[i] && y < va[i]) ? 1 : 0;
          e_hs[i] = (x >= ha[i] + hfp[i] && x < ha[i] + hfp[i] + hsw[i]) ? pol[i] : 1 - pol[i];
          e_vs[i] = (y >= va[i] + vfp[i] && y < va[i] + vfp[i] + vsw[i]) ? pol[i] : 1 - pol[i];
          e_ls[i] = (x == 0) ? 1 : 0;
          e_fs[i] = (x == 0 && y == 0) ? 1 : 0;
          if (e_fs[i] == 1) e_fc[i] = (e_fc[i] + 1) % fmod[i];
        end
        if (enable) en_cnt[i]++;
      end
    end
    #2;
    chk("pix_tick", 0, a_tick, e_tick[0]);    chk("pix_tick", 1, b_tick, e_tick[1]);
    chk("pixel_x", 0, a_x, e_x[0]);           chk("pixel_x", 1, b_x, e_x[1]);
    chk("pixel_y", 0, a_y, e_y[0]);           chk("pixel_y", 1, b_y, e_y[1]);
    chk("h_sync", 0, a_hs, e_hs[0]);          chk("h_sync", 1, b_hs, e_hs[1]);
    chk("v_sync", 0, a_vs, e_vs[0]);          chk("v_sync", 1, b_vs, e_vs[1]);
    chk("video_on", 0, a_von, e_von[0]);      chk("video_on", 1, b_von, e_von[1]);
    chk("line_start", 0, a_ls, e_ls[0]);      chk("line_start", 1, b_ls, e_ls[1]);
    chk("frame_start", 0, a_fs, e_fs[0]);     chk("frame_start", 1, b_fs, e_fs[1]);
    chk("frame_cnt", 0, a_fc, e_fc[0]);       chk("frame_cnt", 1, b_fc, e_fc[1]);
  end

  initial begin
    longint t0;
    int fc_save, n;
    reset = 1'b1; enable = 1'b1; restart = 1'b0;
    repeat (3) @(negedge clk);
    lit("rst_a_x", a_x, 0);   lit("rst_a_hs", a_hs, 1);  lit("rst_a_vs", a_vs, 1);
    lit("rst_b_hs", b_hs, 0); lit("rst_a_fc", a_fc, 0);  lit("rst_a_von", a_von, 0);
    reset = 1'b0;

    wait_a(0, 0, 10);
    lit("first_fs", a_fs, 1);  lit("first_fc", a_fc, 1);  lit("first_ls", a_ls, 1);
    lit("first_b_fc", b_fc, 1);

    wait_a(639, 0, 4000);  lit("von_639", a_von, 1);
    wait_a(640, 0, 10);    lit("von_640", a_von, 0);
    wait_a(655, 0, 100);   lit("hs_655", a_hs, 1);
    wait_a(656, 0, 10);    lit("hs_656", a_hs, 0);
    wait_a(751, 0, 400);   lit("hs_751", a_hs, 0);
    wait_a(752, 0, 10);    lit("hs_752", a_hs, 1);
    wait_a(799, 0, 200);
    wait_a(0, 1, 10);      lit("wrap_ls", a_ls, 1);

    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ls && n < 3000);
    lit("line_period", cyc - t0, 1600);

    wait_a(0, 0, 20000);
    t0 = cyc;
    wait_a(5, 5, 20000);   lit("von_5_5", a_von, 1);
    wait_a(0, 6, 2000);    lit("von_0_6", a_von, 0);  lit("vs_6", a_vs, 1);
    wait_a(0, 7, 2000);    lit("vs_7", a_vs, 0);
    wait_a(0, 8, 2000);    lit("vs_8", a_vs, 0);
    wait_a(0, 9, 2000);    lit("vs_9", a_vs, 1);
    wait_a(0, 0, 4000);    lit("frame_period", cyc - t0, 17600);  lit("wrap_fs", a_fs, 1);

    wait_a(100, 3, 20000);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      lit("frz_tick", a_tick, 0);
      lit("frz_x", a_x, 100);
    end
    enable = 1'b1;
    wait_a(101, 3, 4);

    wait_a(300, 4, 20000);
    fc_save = a_fc;
    enable = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; enable = 1'b1;
    wait_a(0, 0, 4);
    lit("rs_fs", a_fs, 1);
    lit("rs_fc", a_fc, (fc_save + 1) % 65536);

    repeat (500 + $urandom_range(0, 300)) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    lit("mid_x", a_x, 0);   lit("mid_hs", a_hs, 1);  lit("mid_vs", a_vs, 1);
    lit("mid_fc", a_fc, 0); lit("mid_b_fc", b_fc, 0); lit("mid_tick", a_tick, 0);
    reset = 1'b0;

    for (int k = 0; k < 40; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    restart = 1'b0; enable = 1'b1;
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
